inst_queue: RTL

//  Instruction FIFO between instruction fetch (IF) and the decoder.
//  - Buffers fetched {inst, pc} pairs and presents them one per cycle on a registered output stage.
//  - Gives back-pressure to IF through a full flag.
//  - Is flushed on branch mispredict or JAL redirect.
//  - Fills the decoder's inst/pc inputs, which the decoder samples every clock.

---
 rtl/inst_queue_if.sv | 30 +++
 rtl/inst_queue.sv | 111 +++++++++++
 2 files changed

// File: rtl/inst_queue_if.sv
// Fetch/decode bus of the instruction queue: the IF push side and the decoder pull side.
interface inst_queue_if #(
    parameter int IDW = 32,
    parameter int AW  = 32
);
    logic           if_instqueue_en_in;
    logic [IDW-1:0] if_instqueue_inst_in;
    logic [AW-1:0]  if_instqueue_pc_in;
    logic           instqueue_if_full_out;
    logic           decoder_instqueue_ready_in;
    logic           instqueue_decoder_valid_out;
    logic [IDW-1:0] instqueue_decoder_inst_out;
    logic [AW-1:0]  instqueue_decoder_pc_out;

    // Environment side: fetch pushes, decoder accepts.
    modport master (
        output if_instqueue_en_in, if_instqueue_inst_in, if_instqueue_pc_in,
        output decoder_instqueue_ready_in,
        input  instqueue_if_full_out,
        input  instqueue_decoder_valid_out, instqueue_decoder_inst_out, instqueue_decoder_pc_out
    );

    // Queue side.
    modport slave (
        input  if_instqueue_en_in, if_instqueue_inst_in, if_instqueue_pc_in,
        input  decoder_instqueue_ready_in,
        output instqueue_if_full_out,
        output instqueue_decoder_valid_out, instqueue_decoder_inst_out, instqueue_decoder_pc_out
    );
endinterface

// File: rtl/inst_queue.sv
// Instruction FIFO between fetch and decode: circular storage of {inst, pc}
// feeding a registered output stage, with flush and global freeze.
module inst_queue #(
    parameter int             DEPTH_LOG2 = 4,
    parameter int             IDW        = 32,
    parameter int             AW         = 32,
    parameter logic [IDW-1:0] NOP_INST   = 32'h00000013
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         clear_in,
    inst_queue_if.slave  q
);
    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [IDW-1:0]        mem_inst [DEPTH];
    logic [AW-1:0]         mem_pc   [DEPTH];

    logic [DEPTH_LOG2-1:0] head_q, head_d;
    logic [DEPTH_LOG2-1:0] tail_q, tail_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  valid_q, valid_d;
    logic [IDW-1:0]        inst_q, inst_d;
    logic [AW-1:0]         pc_q, pc_d;

    logic full;
    logic push;
    logic advance;
    logic pop;

    // Back-pressure is a pure decode of the registered count.
    assign full    = (count_q == FULL_CNT);
    assign push    = q.if_instqueue_en_in && !full;
    assign advance = !valid_q || q.decoder_instqueue_ready_in;
    assign pop     = advance && (count_q != '0);

    assign q.instqueue_if_full_out       = full;
    assign q.instqueue_decoder_valid_out = valid_q;
    assign q.instqueue_decoder_inst_out  = inst_q;
    assign q.instqueue_decoder_pc_out    = pc_q;

    // Next-state: freeze, then flush, then independent push and advance.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (rdy_in) begin
            if (clear_in) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                valid_d = 1'b0;
                inst_d  = NOP_INST;
                pc_d    = '0;
            end else begin
                if (push) begin
                    tail_d = tail_q + 1'b1;
                end
                if (advance) begin
                    if (pop) begin
                        valid_d = 1'b1;
                        inst_d  = mem_inst[head_q];
                        pc_d    = mem_pc[head_q];
                        head_d  = head_q + 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        inst_d  = NOP_INST;
                        pc_d    = '0;
                    end
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    // Control and output stage registers, cleared by the asynchronous reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            pc_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    // Storage array write; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !clear_in && push) begin
            mem_inst[tail_q] <= q.if_instqueue_inst_in;
            mem_pc[tail_q]   <= q.if_instqueue_pc_in;
        end
    end
endmodule
